datapath: RTL and testbench

- Data-side counterpart of the K&S multicycle processor control unit.
- Holds PC, IR, a 4x16 register file, the ALU and the flags register.
- Decodes the IR into `decoded_instruction` for the control unit and drives memory address and write data.
- Acts on the control unit's enables cycle by cycle and returns registered flags.

---
 rtl/datapath.sv | 128 ++++++++++++
 tb/tb_datapath.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// datapath: K&S multicycle datapath with PC, IR, 4x16 register file, ALU and flags.
// Optional KS_R0_ZERO_EN hardwires R0 to zero.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;
endpackage

module datapath
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] rf [4];
    logic [1:0]        a_sel, b_sel, dst;
    logic [DATA_W-1:0] a, b, alu_res, wb;
    logic [DATA_W:0]   sum, diff;
    logic              carry, sovf, wr_ok;
    logic              unused_ir7;

    assign unused_ir7 = ir[7];

    function automatic logic [DATA_W-1:0] rd(input logic [1:0] i);
`ifdef KS_R0_ZERO_EN
        return (i == 2'd0) ? '0 : rf[i];
`else
        return rf[i];
`endif
    endfunction

    always_comb begin
        case (ir[15:8])
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNZERO;
            8'h04:   decoded_instruction = I_BNEG;
            8'h05:   decoded_instruction = I_BNNEG;
            8'h06:   decoded_instruction = I_BOV;
            8'h07:   decoded_instruction = I_BNOV;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // MOVE routes src to both ALU inputs so AND passes it through unchanged
    assign a_sel = (decoded_instruction == I_MOVE) ? ir[1:0] : ir[3:2];
    assign b_sel = ir[1:0];
    assign dst   = (decoded_instruction == I_LOAD) ? ir[6:5] :
                   (decoded_instruction == I_MOVE) ? ir[3:2] : ir[5:4];
    assign a     = rd(a_sel);
    assign b     = rd(b_sel);

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = (operation == 2'b00) ? sum[DATA_W-1:0] :
                  (operation == 2'b01) ? diff[DATA_W-1:0] :
                  (operation == 2'b10) ? (a & b) : (a | b);
        carry   = (operation == 2'b00) ? sum[DATA_W] :
                  (operation == 2'b01) ? diff[DATA_W] : 1'b0;
        sovf    = (operation == 2'b00) ? ((a[DATA_W-1] == b[DATA_W-1]) && (alu_res[DATA_W-1] != a[DATA_W-1])) :
                  (operation == 2'b01) ? ((a[DATA_W-1] != b[DATA_W-1]) && (alu_res[DATA_W-1] != a[DATA_W-1])) :
                  1'b0;
    end

    assign wb       = c_sel ? data_in : alu_res;
    assign ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc;
    assign data_out = rd(ir[6:5]);

`ifdef KS_R0_ZERO_EN
    assign wr_ok = write_reg_enable && (dst != 2'd0);
`else
    assign wr_ok = write_reg_enable;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc                <= '0;
            ir                <= '0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else begin
            if (pc_enable) pc <= branch ? ir[ADDR_W-1:0] : pc + 1'b1;
            if (ir_enable) ir <= data_in;
            if (wr_ok) rf[dst] <= wb;
            if (flags_reg_enable) begin
                zero_op           <= (alu_res == '0);
                neg_op            <= alu_res[DATA_W-1];
                unsigned_overflow <= carry;
                signed_overflow   <= sovf;
            end
        end
    end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed and randomized checks of datapath against an arithmetic reference model.
module tb_datapath;
    import k_and_s_pkg::*;

    logic clk = 0;
    logic rst_n, branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable;
    logic [1:0] operation;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0] ram_addr;
    logic [15:0] data_out, data_in;

    int checks = 0;
    int failures = 0;

    logic [4:0]  m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_r [4];
    logic        m_z, m_n, m_c, m_v;
    logic [7:0]  ops [15];

    datapath dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .write_reg_enable(write_reg_enable), .addr_sel(addr_sel),
        .c_sel(c_sel), .operation(operation), .flags_reg_enable(flags_reg_enable),
        .decoded_instruction(decoded_instruction), .zero_op(zero_op), .neg_op(neg_op),
        .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
        .ram_addr(ram_addr), .data_out(data_out), .data_in(data_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic decoded_instruction_type mdec(input logic [7:0] o);
        case (o)
            8'h81: return I_LOAD;   8'h82: return I_STORE;  8'h91: return I_MOVE;
            8'hA1: return I_ADD;    8'hA2: return I_SUB;    8'hA3: return I_AND;
            8'hA4: return I_OR;     8'h01: return I_BRANCH; 8'h02: return I_BZERO;
            8'h03: return I_BNZERO; 8'h04: return I_BNEG;   8'h05: return I_BNNEG;
            8'h06: return I_BOV;    8'h07: return I_BNOV;   8'hFF: return I_HALT;
            default: return I_NOP;
        endcase
    endfunction

    function automatic logic [15:0] mrd(input logic [1:0] i);
`ifdef KS_R0_ZERO_EN
        if (i == 2'd0) return 16'h0000;
`endif
        return m_r[i];
    endfunction

    task automatic check_outputs();
        chk("decoded", 32'(decoded_instruction), 32'(mdec(m_ir[15:8])));
        chk("ram_addr", 32'(ram_addr), 32'(addr_sel ? m_ir[4:0] : m_pc));
        chk("data_out", 32'(data_out), 32'(mrd(m_ir[6:5])));
        chk("zero_op", 32'(zero_op), 32'(m_z));
        chk("neg_op", 32'(neg_op), 32'(m_n));
        chk("unsigned_ovf", 32'(unsigned_overflow), 32'(m_c));
        chk("signed_ovf", 32'(signed_overflow), 32'(m_v));
    endtask

    // Model computes every next value from pre-edge state, then the edge is taken
    task automatic cycle(input logic rn, input logic pe, input logic ie, input logic we,
                         input logic fe, input logic br, input logic as, input logic cs,
                         input logic [1:0] op, input logic [15:0] din);
        decoded_instruction_type k;
        logic [15:0] av, bv, res, wbv;
        logic [1:0]  dst;
        int ua, ub, sa, sb, s;
        logic c, v;
        rst_n = rn; pc_enable = pe; ir_enable = ie; write_reg_enable = we;
        flags_reg_enable = fe; branch = br; addr_sel = as; c_sel = cs; operation = op; data_in = din;
        k  = mdec(m_ir[15:8]);
        av = mrd(k == I_MOVE ? m_ir[1:0] : m_ir[3:2]);
        bv = mrd(m_ir[1:0]);
        ua = int'(av); ub = int'(bv);
        sa = $signed(av); sb = $signed(bv);
        c = 0; v = 0;
        case (op)
            2'b00: begin s = ua + ub; res = s[15:0]; c = s > 65535; s = sa + sb; v = s > 32767 || s < -32768; end
            2'b01: begin s = ua - ub; res = s[15:0]; c = ua < ub;   s = sa - sb; v = s > 32767 || s < -32768; end
            2'b10: res = av & bv;
            default: res = av | bv;
        endcase
        dst = (k == I_LOAD) ? m_ir[6:5] : (k == I_MOVE) ? m_ir[3:2] : m_ir[5:4];
        wbv = cs ? din : res;
        @(posedge clk);
        #1;
        if (!rn) begin
            m_pc = 0; m_ir = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 0;
        end else begin
            if (pe) m_pc = br ? m_ir[4:0] : 5'((int'(m_pc) + 1) % 32);
            if (ie) m_ir = din;
            if (we) m_r[dst] = wbv;
            if (fe) begin m_z = res == 0; m_n = res[15]; m_c = c; m_v = v; end
        end
        check_outputs();
    endtask

    task automatic idle(input logic [15:0] din = 16'h0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, din);
    endtask

    task automatic set_ir(input logic [15:0] w);
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, w);
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [15:0] val);
        set_ir(16'h8100 | (16'(r) << 5));
        cycle(1, 0, 0, 1, 0, 0, 1, 1, 2'b00, val);
    endtask

    task automatic read_reg(input logic [1:0] r, input logic [15:0] exp, input string tag);
        set_ir(16'h8200 | (16'(r) << 5));
        chk(tag, 32'(data_out), 32'(exp));
    endtask

    initial begin
        ops = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h01,
                8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFF};
        m_pc = 0; m_ir = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;

        cycle(0, 1, 1, 1, 1, 0, 0, 0, 2'b00, 16'hFFFF);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0000);
        chk("reset_pc", 32'(ram_addr), 0);
        chk("reset_dec", 32'(decoded_instruction), 32'(I_NOP));

        cycle(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 16'h8125);
        chk("fetch_pc", 32'(ram_addr), 1);
        chk("fetch_dec", 32'(decoded_instruction), 32'(I_LOAD));

        addr_sel = 1;
        #1 chk("load_addr", 32'(ram_addr), 5);
        cycle(1, 0, 0, 1, 0, 0, 1, 1, 2'b00, 16'h00AB);
        chk("load_r1", 32'(data_out), 32'h00AB);

        load_reg(2, 16'h7FFF);
        load_reg(3, 16'h0001);
        set_ir(16'hA11B);
        cycle(1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 16'h0);
        chk("add_neg", 32'(neg_op), 1);
        chk("add_sovf", 32'(signed_overflow), 1);
        chk("add_uovf", 32'(unsigned_overflow), 0);
        chk("add_zero", 32'(zero_op), 0);
        read_reg(1, 16'h8000, "add_r1");

        load_reg(0, 16'h1234);
        load_reg(1, 16'h1234);
        set_ir(16'hA201);
        cycle(1, 0, 0, 1, 1, 0, 0, 0, 2'b01, 16'h0);
`ifndef KS_R0_ZERO_EN
        chk("sub_zero", 32'(zero_op), 1);
        chk("sub_uovf", 32'(unsigned_overflow), 0);
`endif
        load_reg(0, 16'h1234);
        load_reg(1, 16'h1235);
        set_ir(16'hA201);
        cycle(1, 0, 0, 1, 1, 0, 0, 0, 2'b01, 16'h0);
`ifndef KS_R0_ZERO_EN
        chk("sub_borrow", 32'(unsigned_overflow), 1);
        chk("sub_neg", 32'(neg_op), 1);
        read_reg(0, 16'hFFFF, "sub_r0");
`endif

        for (int i = 0; i < 40 && m_pc != 5'd31; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        chk("pc_at_31", 32'(ram_addr), 31);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        chk("pc_wrap", 32'(ram_addr), 0);
        set_ir(16'h0113);
        chk("br_dec", 32'(decoded_instruction), 32'(I_BRANCH));
        cycle(1, 1, 0, 0, 0, 1, 0, 0, 2'b00, 16'h0);
        chk("br_pc", 32'(ram_addr), 19);

        load_reg(2, 16'hBEEF);
        set_ir(16'h8247);
        cycle(1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 16'h0);
        chk("store_data", 32'(data_out), 32'hBEEF);
        chk("store_addr", 32'(ram_addr), 7);
        set_ir(16'h9102);
        chk("move_dec", 32'(decoded_instruction), 32'(I_MOVE));
        cycle(1, 0, 0, 1, 0, 0, 0, 0, 2'b10, 16'h0);
`ifdef KS_R0_ZERO_EN
        read_reg(0, 16'h0000, "move_r0");
`else
        read_reg(0, 16'hBEEF, "move_r0");
`endif

        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 2) != 0) d[15:8] = ops[$urandom_range(0, 14)];
            cycle($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), d);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
